pipe_hazard_ctrl: RTL and testbench

Parametrised pipeline hazard and stall/flush controller for the CPU core, replacing the fixed 5-stage combinational hazard unit. It generates per-buffer stall and flush vectors for a pipeline of NUM_STAGES stages, which may include multi-cycle memory stages. Internally it tracks in-flight loads for load-use detection, runs a memory-wait FSM with an optional timeout, and runs an interrupt-entry FSM with a pending latch and masking until return-from-interrupt.

---
 rtl/cpu_pipe_pkg.sv | 12 +
 rtl/load_scoreboard.sv | 87 ++++++++
 rtl/pipe_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared types and buffer indices for the CPU pipeline control blocks.
package cpu_pipe_pkg;

   typedef enum logic {MIDLE, MWAIT} mem_fsm_t;
   typedef enum logic {RUN, SERVICE} int_fsm_t;

   localparam int BUF_IFID   = 0;
   localparam int BUF_IDEX   = 1;
   localparam int BUF_EXMEM  = 2;
   localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/load_scoreboard.sv
// In-flight load tracker: flags a used ID source that matches a load in EX or
// in any MEM stage whose result cannot yet be forwarded.
module load_scoreboard
   import cpu_pipe_pkg::*;
#(
   parameter int NUM_STAGES = 5,
   parameter int REG_ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [REG_ADDR_W-1:0] ex_reg_dst,
   input  logic                  ex_is_load,
   input  logic [NUM_STAGES-2:0] stall,
   input  logic [NUM_STAGES-2:0] flush,
   output logic                  hazard
);

   // Registered entries cover MEM stages 3..NUM_STAGES-3; the last MEM stage forwards.
   localparam int DEPTH = NUM_STAGES - 5;

   logic ex_hit, trk_hit;

   assign ex_hit = ex_is_load &
                   ((id_rs1_used & (id_rs1 == ex_reg_dst)) |
                    (id_rs2_used & (id_rs2 == ex_reg_dst)));

   generate
      if (DEPTH > 0) begin : g_trk
         logic [DEPTH-1:0]                 vld_pipe, vld_in;
         logic [DEPTH-1:0][REG_ADDR_W-1:0] dst_pipe, dst_in;

         always_comb begin
            vld_in    = '0;
            dst_in    = '0;
            vld_in[0] = ex_is_load;
            dst_in[0] = ex_reg_dst;
            for (int k = 1; k < DEPTH; k++) begin
               vld_in[k] = vld_pipe[k-1];
               dst_in[k] = dst_pipe[k-1];
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_pipe <= '0;
               dst_pipe <= '0;
            end else begin
               for (int k = 0; k < DEPTH; k++) begin
                  if (flush[BUF_EXMEM+k]) begin
                     vld_pipe[k] <= 1'b0;
                  end else if (!stall[BUF_EXMEM+k]) begin
                     vld_pipe[k] <= vld_in[k];
                     dst_pipe[k] <= dst_in[k];
                  end
               end
            end
         end

         always_comb begin
            trk_hit = 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
               if (vld_pipe[k] &&
                   ((id_rs1_used && (id_rs1 == dst_pipe[k])) ||
                    (id_rs2_used && (id_rs2 == dst_pipe[k]))))
                  trk_hit = 1'b1;
            end
         end

         logic unused_bits;
         assign unused_bits = ^{stall[BUF_EXMEM-1:0], flush[BUF_EXMEM-1:0],
                                stall[NUM_STAGES-2:BUF_EXMEM+DEPTH],
                                flush[NUM_STAGES-2:BUF_EXMEM+DEPTH]};
      end else begin : g_no_trk
         assign trk_hit = 1'b0;

         logic unused_bits;
         assign unused_bits = ^{clk, rst_n, stall, flush};
      end
   endgenerate

   assign hazard = ex_hit | trk_hit;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: memory wait, interrupt entry, load-use and
// redirect. Define PIPE_HAZ_TIMEOUT_EN to bound memory waits by MEM_TIMEOUT.
module pipe_hazard_ctrl
   import cpu_pipe_pkg::*;
#(
   parameter int NUM_STAGES  = 5,
   parameter int REG_ADDR_W  = 4,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [REG_ADDR_W-1:0] ex_reg_dst,
   input  logic                  ex_is_load,
   input  logic                  branch_miss,
   input  logic                  id_redirect,
   input  logic                  mem_req,
   input  logic                  mem_valid,
   input  logic                  alert,
   input  logic                  int_enable,
   input  logic                  reti,
   input  logic                  err_clr,
   output logic [NUM_STAGES-2:0] stall,
   output logic [NUM_STAGES-2:0] flush,
   output logic                  pc_hold,
   output logic                  int_take,
   output logic                  int_active,
   output logic                  mem_timeout_err
);

   mem_fsm_t mem_state, mem_next;
   int_fsm_t int_state, int_next;
   logic     pending, take, load_use;
   logic     mem_wait_raw, mem_stall, timeout;
   logic     [NUM_STAGES-2:0] stall_c, flush_c;
   logic     pc_hold_c, int_take_c;

   assign mem_wait_raw = mem_req & ~mem_valid;
   assign mem_stall    = mem_wait_raw & ~timeout;

`ifdef PIPE_HAZ_TIMEOUT_EN
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic                  err;

   assign timeout = (mem_state == MWAIT) &&
                    (wait_cnt == WAIT_CNT_W'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
         err      <= 1'b0;
      end else begin
         if (mem_state == MIDLE)
            wait_cnt <= '0;
         else if (wait_cnt != '1)
            wait_cnt <= wait_cnt + 1'b1;
         // A timeout in the same cycle as err_clr keeps the flag set.
         if (timeout)
            err <= 1'b1;
         else if (err_clr)
            err <= 1'b0;
      end
   end

   assign mem_timeout_err = err;
`else
   localparam int unused_timeout = MEM_TIMEOUT;
   logic unused_clr;

   assign timeout         = 1'b0;
   assign mem_timeout_err = 1'b0;
   assign unused_clr      = err_clr;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_state <= MIDLE;
         int_state <= RUN;
         pending   <= 1'b0;
      end else begin
         mem_state <= mem_next;
         int_state <= int_next;
         pending   <= (pending & ~take) | (alert & int_enable);
      end
   end

   assign take = (int_state == RUN) & pending & ~mem_stall & ~branch_miss;

   always_comb begin
      mem_next = mem_state;
      int_next = int_state;
      case (mem_state)
         MIDLE:   if (mem_wait_raw) mem_next = MWAIT;
         MWAIT:   if (timeout || mem_valid) mem_next = MIDLE;
         default: mem_next = MIDLE;
      endcase
      case (int_state)
         RUN:     if (take) int_next = SERVICE;
         SERVICE: if (reti) int_next = RUN;
         default: int_next = RUN;
      endcase
   end

   load_scoreboard #(
      .NUM_STAGES (NUM_STAGES),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_sb (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rs1_used (id_rs1_used),
      .id_rs2_used (id_rs2_used),
      .ex_reg_dst  (ex_reg_dst),
      .ex_is_load  (ex_is_load),
      .stall       (stall_c),
      .flush       (flush_c),
      .hazard      (load_use)
   );

   always_comb begin
      stall_c    = '0;
      flush_c    = '0;
      pc_hold_c  = 1'b0;
      int_take_c = 1'b0;
      if (mem_stall) begin
         stall_c   = '1;
         pc_hold_c = 1'b1;
      end else if (branch_miss) begin
         flush_c[BUF_IFID] = 1'b1;
         flush_c[BUF_IDEX] = 1'b1;
      end else if (take) begin
         int_take_c        = 1'b1;
         flush_c[BUF_IFID] = 1'b1;
         flush_c[BUF_IDEX] = 1'b1;
      end else if (load_use) begin
         stall_c[BUF_IFID] = 1'b1;
         flush_c[BUF_IDEX] = 1'b1;
         pc_hold_c         = 1'b1;
      end else if (id_redirect) begin
         flush_c[BUF_IFID] = 1'b1;
      end
   end

   // Outputs go quiet the moment reset asserts, even with live requests present.
   assign stall      = rst_n ? stall_c : '0;
   assign flush      = rst_n ? flush_c : '0;
   assign pc_hold    = rst_n & pc_hold_c;
   assign int_take   = rst_n & int_take_c;
   assign int_active = (int_state == SERVICE);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: 5- and 6-stage instances against a reference model.
module tb_pipe_hazard_ctrl;

   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] id_rs1, id_rs2, ex_reg_dst;
   logic       id_rs1_used, id_rs2_used, ex_is_load, branch_miss, id_redirect;
   logic       mem_req, mem_valid, alert, int_enable, reti, err_clr;

   logic [3:0] stall5, flush5;
   logic [4:0] stall6, flush6;
   logic       pc_hold5, int_take5, int_active5, err5;
   logic       pc_hold6, int_take6, int_active6, err6;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model state
   bit m_wait, m_err, pend, in_svc;
   int m_cnt;
   int ld_at [8];   // destination of a load sitting in stage s, -1 if none

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.NUM_STAGES(5), .REG_ADDR_W(4), .MEM_TIMEOUT(TO)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_reg_dst(ex_reg_dst), .ex_is_load(ex_is_load),
      .branch_miss(branch_miss), .id_redirect(id_redirect),
      .mem_req(mem_req), .mem_valid(mem_valid), .alert(alert),
      .int_enable(int_enable), .reti(reti), .err_clr(err_clr),
      .stall(stall5), .flush(flush5), .pc_hold(pc_hold5), .int_take(int_take5),
      .int_active(int_active5), .mem_timeout_err(err5));

   pipe_hazard_ctrl #(.NUM_STAGES(6), .REG_ADDR_W(4), .MEM_TIMEOUT(TO)) u_dut6 (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_reg_dst(ex_reg_dst), .ex_is_load(ex_is_load),
      .branch_miss(branch_miss), .id_redirect(id_redirect),
      .mem_req(mem_req), .mem_valid(mem_valid), .alert(alert),
      .int_enable(int_enable), .reti(reti), .err_clr(err_clr),
      .stall(stall6), .flush(flush6), .pc_hold(pc_hold6), .int_take(int_take6),
      .int_active(int_active6), .mem_timeout_err(err6));

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      n_assert++;
      assert (obs === 32'(exp)) else begin
         n_fail++;
         $error("FAIL %s @%0t: got %0d, expected %0d", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_wait = 0; m_err = 0; pend = 0; in_svc = 0; m_cnt = 0;
      foreach (ld_at[s]) ld_at[s] = -1;
   endtask

   function automatic bit src_hit(input int d);
      return (id_rs1_used && int'(id_rs1) == d) || (id_rs2_used && int'(id_rs2) == d);
   endfunction

   // Loads in EX or in any MEM stage short of the last one (n-2) block ID.
   function automatic bit load_use(input int n);
      bit h = ex_is_load && src_hit(int'(ex_reg_dst));
      for (int s = 3; s <= n - 3; s++)
         if (ld_at[s] >= 0 && src_hit(ld_at[s])) h = 1;
      return h;
   endfunction

   task automatic expect_n(input int n, input bit ms, input bit tk,
                           output int es, output int ef, output int ep, output int et);
      es = 0; ef = 0; ep = 0; et = 0;
      if (!rst_n) return;
      if (ms)               begin es = (1 << (n - 1)) - 1; ep = 1; end
      else if (branch_miss) ef = 3;
      else if (tk)          begin ef = 3; et = 1; end
      else if (load_use(n)) begin es = 1; ef = 2; ep = 1; end
      else if (id_redirect) ef = 1;
   endtask

   // Check the current cycle, then advance model and clock by one cycle.
   task automatic step(input string tag);
      bit raw, tmo, ms, tk;
      int es, ef, ep, et;
      #2;
      if (!rst_n) model_reset();
      raw = mem_req && !mem_valid;
`ifdef PIPE_HAZ_TIMEOUT_EN
      tmo = m_wait && (m_cnt == TO - 1);
`else
      tmo = 0;
`endif
      ms = raw && !tmo;
      tk = rst_n && !in_svc && pend && !ms && !branch_miss;

      expect_n(5, ms, tk, es, ef, ep, et);
      chk({tag, " stall5"}, 32'(stall5), es);
      chk({tag, " flush5"}, 32'(flush5), ef);
      chk({tag, " pc_hold5"}, 32'(pc_hold5), ep);
      chk({tag, " int_take5"}, 32'(int_take5), et);
      expect_n(6, ms, tk, es, ef, ep, et);
      chk({tag, " stall6"}, 32'(stall6), es);
      chk({tag, " flush6"}, 32'(flush6), ef);
      chk({tag, " pc_hold6"}, 32'(pc_hold6), ep);
      chk({tag, " int_take6"}, 32'(int_take6), et);
      chk({tag, " int_active5"}, 32'(int_active5), int'(in_svc));
      chk({tag, " int_active6"}, 32'(int_active6), int'(in_svc));
      chk({tag, " err5"}, 32'(err5), int'(m_err));
      chk({tag, " err6"}, 32'(err6), int'(m_err));

      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         if (!m_wait) begin
            if (raw) begin m_wait = 1; m_cnt = 0; end
         end else if (tmo || mem_valid) begin
            m_wait = 0;
         end else begin
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
         end
         if (tmo) m_err = 1;
         else if (err_clr) m_err = 0;
         if (tk) in_svc = 1;
         else if (in_svc && reti) in_svc = 0;
         pend = (pend && !tk) || (alert && int_enable);
         if (!ms) begin
            for (int s = 7; s > 3; s--) ld_at[s] = ld_at[s-1];
            ld_at[3] = ex_is_load ? int'(ex_reg_dst) : -1;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
      ex_reg_dst = 0; ex_is_load = 0; branch_miss = 0; id_redirect = 0;
      mem_req = 0; mem_valid = 0; alert = 0; int_enable = 1; reti = 0; err_clr = 0;
   endtask

   initial begin
      idle();
      rst_n = 0;
      model_reset();
      @(negedge clk);
      step("reset"); step("reset");
      rst_n = 1;
      step("idle");

      // load-use: 1 cycle on 5 stages, 2 cycles on 6 stages
      ex_is_load = 1; ex_reg_dst = 3; id_rs1 = 3; id_rs1_used = 1;
      step("lu0");
      ex_is_load = 0; ex_reg_dst = 0;
      step("lu1"); step("lu2"); step("lu3");
      idle();
      id_redirect = 1; step("redirect");
      idle();

      // bounded memory wait released by mem_valid
      mem_req = 1;
      step("mw0"); step("mw1"); step("mw2");
      mem_valid = 1; step("mw_rel");
      idle(); step("mw_after");

      // stuck memory: timeout when enabled, endless stall otherwise
      mem_req = 1;
      for (int i = 0; i < 5; i++) step("to");
      mem_req = 0; step("to_post"); step("to_post");
      err_clr = 1; step("to_clr");
      err_clr = 0; step("to_clr_after");

      // interrupt entry, pending during service, return
      alert = 1; step("int_alert");
      alert = 0; step("int_take");
      step("int_active");
      alert = 1; step("int_alert2");
      alert = 0; step("int_wait"); step("int_wait");
      reti = 1; step("int_reti");
      reti = 0; step("int_take2");
      alert = 1; reti = 1; step("int_reti_alert");
      alert = 0; reti = 0; step("int_take3");

      // branch_miss defers a pending interrupt by one cycle
      alert = 1; step("bm_alert");
      alert = 0; reti = 1; step("bm_reti");
      reti = 0; branch_miss = 1; step("bm_collide");
      branch_miss = 0; step("bm_take");
      reti = 1; step("bm_ret");
      idle();

      // reset in the middle of a memory wait
      mem_req = 1;
      step("rw0"); step("rw1"); step("rw2");
      rst_n = 0; step("rw_rst");
      mem_req = 0; rst_n = 1; step("rw_after"); step("rw_after");
      mem_req = 1; step("rw_new");
      idle(); mem_valid = 1; step("rw_done");
      idle();

      for (int i = 0; i < 600; i++) begin
         rst_n       = ($urandom_range(0, 99) != 0);
         id_rs1      = 4'($urandom_range(0, 3));
         id_rs2      = 4'($urandom_range(0, 3));
         id_rs1_used = 1'($urandom);
         id_rs2_used = 1'($urandom);
         ex_reg_dst  = 4'($urandom_range(0, 3));
         ex_is_load  = ($urandom_range(0, 2) == 0);
         branch_miss = ($urandom_range(0, 7) == 0);
         id_redirect = ($urandom_range(0, 5) == 0);
         mem_req     = ($urandom_range(0, 3) == 0);
         mem_valid   = ($urandom_range(0, 2) == 0);
         alert       = ($urandom_range(0, 9) == 0);
         int_enable  = ($urandom_range(0, 3) != 0);
         reti        = ($urandom_range(0, 7) == 0);
         err_clr     = ($urandom_range(0, 4) == 0);
         step("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
